// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker and the 64-bit big-endian bit length, and hands blocks downstream.
module sha1_pad #(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_first,
    output logic         block_last
);

    localparam int unsigned BLK_W    = 512;
    localparam int unsigned PTR_W    = 6;
    localparam int unsigned BITLEN_W = 64;
    localparam logic [PTR_W-1:0] PTR_LEN  = PTR_W'(56);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(63);

    typedef enum logic [1:0] {ACCUM, PAD80, LEN, EMIT} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic               first_q, first_d;
    logic               pend_len_q, pend_len_d;
    logic               pend_pad_q, pend_pad_d;
    logic               in_ready_q, in_ready_d;
    logic               valid_q, valid_d;
    logic               bfirst_q, bfirst_d;
    logic               blast_q, blast_d;

    logic [BITLEN_W-1:0] bit_len_c;
    logic [7:0]          len_byte_c;
    logic [8:0]          wr_lsb_c;
    logic                wr_en_c;
    logic [7:0]          wr_byte_c;

    // Byte 0 sits at the top of the block, so the bit offset is (63-ptr)*8.
    assign bit_len_c  = BITLEN_W'({count_q, 3'b000});
    assign len_byte_c = bit_len_c[{~ptr_q[2:0], 3'b000} +: 8];
    assign wr_lsb_c   = {~ptr_q, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            ptr_q      <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            first_q    <= 1'b1;
            pend_len_q <= 1'b0;
            pend_pad_q <= 1'b0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            bfirst_q   <= 1'b0;
            blast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            first_q    <= first_d;
            pend_len_q <= pend_len_d;
            pend_pad_q <= pend_pad_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            bfirst_q   <= bfirst_d;
            blast_q    <= blast_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        buf_d      = buf_q;
        first_d    = first_q;
        pend_len_d = pend_len_q;
        pend_pad_d = pend_pad_q;
        blast_d    = 1'b0;
        wr_en_c    = 1'b0;
        wr_byte_c  = 8'h00;

        case (state_q)
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    wr_en_c   = 1'b1;
                    wr_byte_c = in_data;
                    ptr_d     = PTR_W'(ptr_q + PTR_W'(1));
                    count_d   = LEN_W'(count_q + LEN_W'(1));
                    // A final byte filling the block defers the 0x80 to the next block.
                    if (in_last && ptr_q == PTR_LAST) begin
                        state_d    = EMIT;
                        pend_pad_d = 1'b1;
                    end else if (in_last) begin
                        state_d = PAD80;
                    end else if (ptr_q == PTR_LAST) begin
                        state_d = EMIT;
                    end
                end
            end
            PAD80: begin
                wr_en_c   = 1'b1;
                wr_byte_c = 8'h80;
                if (ptr_q < PTR_LEN) begin
                    ptr_d   = PTR_LEN;
                    state_d = LEN;
                end else begin
                    ptr_d      = PTR_W'(ptr_q + PTR_W'(1));
                    state_d    = EMIT;
                    pend_len_d = 1'b1;
                end
            end
            LEN: begin
                wr_en_c   = 1'b1;
                wr_byte_c = len_byte_c;
                ptr_d     = PTR_W'(ptr_q + PTR_W'(1));
                if (ptr_q == PTR_LAST) begin
                    state_d = EMIT;
                    blast_d = 1'b1;
                end
            end
            EMIT: begin
                blast_d = blast_q;
                if (block_ready) begin
                    buf_d   = '0;
                    ptr_d   = '0;
                    blast_d = 1'b0;
                    first_d = blast_q;
                    if (pend_len_q) begin
                        state_d    = LEN;
                        ptr_d      = PTR_LEN;
                        pend_len_d = 1'b0;
                    end else if (pend_pad_q) begin
                        state_d    = PAD80;
                        pend_pad_d = 1'b0;
                    end else begin
                        state_d = ACCUM;
                        if (blast_q) begin
                            count_d = '0;
                        end
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        if (wr_en_c) begin
            buf_d[wr_lsb_c +: 8] = wr_byte_c;
        end
    end

    // Output flags are registered and track the state being entered.
    assign in_ready_d = (state_d == ACCUM);
    assign valid_d    = (state_d == EMIT);
    assign bfirst_d   = (state_d == EMIT) && first_q;

    assign in_ready    = in_ready_q;
    assign block       = buf_q;
    assign block_valid = valid_q;
    assign block_first = bfirst_q;
    assign block_last  = blast_q;

endmodule

// File: tb/tb_sha1_pad.sv
// Self-checking bench for sha1_pad: a padding model feeds an expected-block
// scoreboard, plus hand sequences for stall, reset and latency corners.
module tb_sha1_pad;

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block;
    logic         block_valid;
    logic         block_ready;
    logic         block_first;
    logic         block_last;

    sha1_pad #(.LEN_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_first (block_first),
        .block_last  (block_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    typedef struct {
        int         len;
        logic [7:0] seed;
        logic [7:0] step;
        int         nblk;
    } vec_t;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   blocks_seen;

    task automatic chk_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference padding: data, 0x80, zeros, 64-bit big-endian bit length.
    task automatic push_expected(input int len, input logic [7:0] seed, input logic [7:0] step);
        logic [7:0]  p [0:191];
        logic [63:0] bl;
        int          nb;
        exp_t        e;
        nb = (len + 8) / 64 + 1;
        for (int j = 0; j < 192; j++) p[j] = 8'h00;
        for (int j = 0; j < len; j++) p[j] = 8'(int'(seed) + j * int'(step));
        p[len] = 8'h80;
        bl = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[nb*64 - 8 + k] = bl[63 - 8*k -: 8];
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++) e.blk[511 - 8*j -: 8] = p[b*64 + j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bytes(input int len, input logic [7:0] seed, input logic [7:0] step,
                              input bit with_last);
        for (int i = 0; i < len; i++) begin
            bit rdy;
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'(int'(seed) + i * int'(step));
                in_last  = with_last && (i == len - 1);
                rdy      = in_ready;
                @(posedge clk);
                guard++;
            end while (!rdy && guard < 500);
            if (!rdy) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: byte %0d of %0d not accepted", i, len);
                #1 in_valid = 1'b0;
                return;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int len, input logic [7:0] seed, input logic [7:0] step);
        push_expected(len, seed, step);
        send_bytes(len, seed, step, 1'b1);
    endtask

    task automatic wait_drain(input string nm);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        chk_int(nm, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int guard;
        guard = 0;
        while (!block_valid && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_bit(nm, block_valid, 1'b1);
    endtask

    // Scoreboard: a block transfers at the edge after a cycle with valid and ready high.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && block_valid) begin
            if (in_ready) chk_bit("in_ready_during_emit", in_ready, 1'b0);
            if (block_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_block: got %h", block);
                end else begin
                    e = exp_q.pop_front();
                    chk_blk("block_data", block, e.blk);
                    chk_bit("block_first", block_first, e.first);
                    chk_bit("block_last", block_last, e.last);
                end
                blocks_seen++;
            end
        end
    end

    initial begin
        vec_t vecs [10];
        int   b0;
        int   cyc;

        vecs[0] = '{3,   8'h61, 8'h01, 1};
        vecs[1] = '{3,   8'h61, 8'h01, 1};
        vecs[2] = '{1,   8'h00, 8'h07, 1};
        vecs[3] = '{55,  8'h10, 8'h03, 1};
        vecs[4] = '{56,  8'h20, 8'h05, 2};
        vecs[5] = '{63,  8'h01, 8'h01, 2};
        vecs[6] = '{64,  8'h00, 8'h01, 2};
        vecs[7] = '{65,  8'h05, 8'h09, 2};
        vecs[8] = '{119, 8'h03, 8'h03, 2};
        vecs[9] = '{120, 8'h07, 8'h0B, 3};

        n_checks    = 0;
        n_errors    = 0;
        blocks_seen = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        block_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_block_valid", block_valid, 1'b0);
        chk_bit("rst_block_first", block_first, 1'b0);
        chk_bit("rst_block_last", block_last, 1'b0);
        chk_blk("rst_block", block, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_bit("in_ready_after_rst", in_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            b0 = blocks_seen;
            send_msg(vecs[i].len, vecs[i].seed, vecs[i].step);
            if (i == 0) begin
                cyc = 0;
                while (!block_valid && cyc < 50) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk_int("abc_latency", cyc, 9);
                chk_blk("abc_literal", block, ABC_BLK);
            end
            wait_drain("drain_vec");
            chk_int("blocks_per_msg", blocks_seen - b0, vecs[i].nblk);
        end

        // Downstream stall: block and flags hold, offered bytes are refused.
        @(negedge clk);
        block_ready = 1'b0;
        send_msg(3, 8'h61, 8'h01);
        wait_valid("stall_valid");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hAA;
            in_last  = 1'b1;
            #1;
            chk_blk("stall_block", block, ABC_BLK);
            chk_bit("stall_first", block_first, 1'b1);
            chk_bit("stall_last", block_last, 1'b1);
            chk_bit("stall_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("stall_release_valid", block_valid, 1'b0);
        wait_drain("drain_stall");
        send_msg(3, 8'h61, 8'h01);
        wait_drain("drain_after_stall");

        // Reset mid-message discards the partial block.
        send_bytes(20, 8'h33, 8'h01, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_bit("midmsg_rst_in_ready", in_ready, 1'b0);
        chk_bit("midmsg_rst_valid", block_valid, 1'b0);
        chk_blk("midmsg_rst_block", block, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b0 = blocks_seen;
        send_msg(3, 8'h61, 8'h01);
        wait_drain("drain_after_midmsg_rst");
        chk_int("midmsg_rst_blocks", blocks_seen - b0, 1);

        // Reset while a block is waiting in EMIT drops it silently.
        @(negedge clk);
        block_ready = 1'b0;
        send_msg(3, 8'h61, 8'h01);
        wait_valid("emit_rst_valid");
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_bit("emit_rst_valid_low", block_valid, 1'b0);
        chk_bit("emit_rst_first_low", block_first, 1'b0);
        chk_bit("emit_rst_last_low", block_last, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        block_ready = 1'b1;
        b0 = blocks_seen;
        send_msg(3, 8'h61, 8'h01);
        wait_drain("drain_after_emit_rst");
        chk_int("emit_rst_blocks", blocks_seen - b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
